bus_initiator: RTL
==================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the maximum number of STROBE cycles to wait for bus_ack; legal range 2..255.
REQ-002 SHALL have port clk_sys, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a transfer request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 SHALL have ports req_we (input, 1 bit), req_wtbt (input, 2 bits), req_addr (input, 16 bits) and req_wdata (input, 16 bits): the request fields.
REQ-007 SHALL have ports rsp_valid (output, 1 bit), rsp_rdata (output, 16 bits) and rsp_err (output, 1 bit): transfer completion, read data and timeout flag.
REQ-008 SHALL have ports bus_sync, bus_stb, bus_we (outputs, 1 bit each), bus_wtbt (output, 2 bits), bus_addr and bus_dout (outputs, 16 bits each): the CPU-bus initiator side.
REQ-009 SHALL have ports bus_din (input, 16 bits) and bus_ack (input, 1 bit): responder read data and acknowledge; bus_ack may be combinational from bus_stb.

Function
REQ-010 SHALL implement the FSM states IDLE, ADDR, STROBE and DONE.
REQ-011 SHALL drive req_ready=1 only in IDLE.
REQ-012 SHALL accept a request when req_valid & req_ready, register all request fields, and go IDLE->ADDR.
REQ-013 In ADDR, SHALL drive bus_sync=1, bus_stb=0, and bus_addr/bus_we/bus_wtbt/bus_dout from the registered fields; ADDR->STROBE after exactly one cycle.
REQ-014 In STROBE, SHALL hold bus_sync=1 and bus_stb=1 with address, control and data stable.
REQ-015 In STROBE with bus_ack=1, SHALL capture bus_din into rsp_rdata on reads (rsp_rdata=0 on writes), clear the error flag, and go to DONE.
REQ-016 In DONE, SHALL drive bus_stb=0, bus_sync=0 and rsp_valid=1 for exactly one cycle; DONE->IDLE unconditionally.
REQ-017 Minimum latency: acceptance in cycle 0, ADDR in cycle 1, STROBE in cycle 2, rsp_valid in cycle 3, req_ready again in cycle 4.
REQ-018 SHALL hold rsp_rdata and rsp_err stable from DONE until the next DONE.
REQ-019 SHALL ignore bus_ack in IDLE, ADDR and DONE.
REQ-020 bus_dout SHALL be 0 on reads; bus_we and bus_wtbt SHALL be 0 outside ADDR and STROBE.
REQ-021 SHALL ignore req_valid in non-IDLE states; no request queuing.
REQ-022 bus_stb SHALL have exactly one rising edge per transfer, so edge-detecting responders act exactly once.

Reset
REQ-023 While reset_n=0, the FSM SHALL be IDLE and the outputs SHALL be: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, all bus_* outputs 0, timeout counter 0.
REQ-024 Reset asserted mid-transfer SHALL drop bus_stb and bus_sync immediately and produce no response.
REQ-025 req_ready SHALL rise in the first cycle after reset_n is deasserted.

Configuration
REQ-026 The macro BUS_INITIATOR_TIMEOUT_EN SHALL control the timeout feature.
REQ-027 With BUS_INITIATOR_TIMEOUT_EN defined: an 8-bit counter clears on entering STROBE and increments each STROBE cycle without bus_ack.
REQ-028 With BUS_INITIATOR_TIMEOUT_EN defined: when the counter equals TIMEOUT-1 without bus_ack, the block SHALL go to DONE with rsp_err=1 and rsp_rdata=0.
REQ-029 With BUS_INITIATOR_TIMEOUT_EN defined: bus_ack in the same cycle as the terminal count SHALL win, giving a normal completion.
REQ-030 Without BUS_INITIATOR_TIMEOUT_EN, STROBE SHALL wait indefinitely for bus_ack, rsp_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-031 Read, responder acks on first STROBE cycle with bus_din=16'o001330: rsp_valid in cycle 3, rsp_rdata=16'o001330, rsp_err=0, bus_we=0 throughout.
REQ-032 Write addr=16'o177662, wdata=16'o047400, wtbt=2'b10: bus_dout=16'o047400 and bus_wtbt=2'b10 stable through ADDR and STROBE; exactly one bus_stb rising edge; rsp_rdata=0.
REQ-033 Ack delayed 5 cycles: bus_stb high for 6 cycles, rsp_valid one cycle later, req_ready low until IDLE; a req_valid pulse during the transfer is dropped.
REQ-034 TIMEOUT_EN defined, TIMEOUT=64, no ack: bus_stb high for exactly 64 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; ack arriving on cycle 64 gives rsp_err=0.
REQ-035 reset_n pulsed low in STROBE: bus_stb and bus_sync go 0 asynchronously, no rsp_valid, req_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding CPU-bus initiator. A request is accepted in
// IDLE, presented for one ADDR cycle (SYNC only), then strobed until bus_ack;
// completion is reported for one cycle in DONE. All outputs are registered and
// computed from the next state, so they change together with the FSM.
// Optional feature: define BUS_INITIATOR_TIMEOUT_EN to bound the STROBE wait to
// TIMEOUT cycles and report rsp_err=1 on expiry.
module bus_initiator #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_wtbt,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_sync,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [1:0]  bus_wtbt,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din,
  input  logic        bus_ack
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;

  // Elaboration-time guard on the timeout range
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_initiator: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [BW-1:0]   wtbt_q, wtbt_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            sync_q, sync_d;
  logic            stb_q, stb_d;
  logic            bus_we_q, bus_we_d;
  logic [BW-1:0]   bus_wtbt_q, bus_wtbt_d;
  logic [DW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_dout_q, bus_dout_d;
  logic            xfer_d;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT - 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state, captured request fields and completion data
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wtbt_d  = wtbt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef BUS_INITIATOR_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          wtbt_d  = req_wtbt;
          addr_d  = req_addr;
          wdata_d = req_we ? req_wdata : '0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
`ifdef BUS_INITIATOR_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (bus_ack) begin
          rdata_d = we_q ? '0 : bus_din;
`ifdef BUS_INITIATOR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_DONE;
        end
`ifdef BUS_INITIATOR_TIMEOUT_EN
        else if (cnt_q == TERM_CNT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output values for the cycle the FSM is about to enter
    xfer_d      = (state_d == ST_ADDR) || (state_d == ST_STROBE);
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    sync_d      = xfer_d;
    stb_d       = (state_d == ST_STROBE);
    bus_we_d    = xfer_d && we_d;
    bus_wtbt_d  = xfer_d ? wtbt_d : '0;
    bus_addr_d  = xfer_d ? addr_d : '0;
    bus_dout_d  = xfer_d ? wdata_d : '0;
  end

  // State, request fields and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      wtbt_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      sync_q      <= 1'b0;
      stb_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_wtbt_q  <= '0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      wtbt_q      <= wtbt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      sync_q      <= sync_d;
      stb_q       <= stb_d;
      bus_we_q    <= bus_we_d;
      bus_wtbt_q  <= bus_wtbt_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
    end
  end

`ifdef BUS_INITIATOR_TIMEOUT_EN
  // STROBE wait counter and error flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign bus_sync  = sync_q;
  assign bus_stb   = stb_q;
  assign bus_we    = bus_we_q;
  assign bus_wtbt  = bus_wtbt_q;
  assign bus_addr  = bus_addr_q;
  assign bus_dout  = bus_dout_q;

endmodule
